cache_arbiter: RTL and testbench

- Two-client request arbiter directly upstream of the byte cache.
- Multiplexes the teletext display fetcher (read-only, latency-critical) and the host port (read/write, optional bypass/combine) onto the cache's single request interface.
- Issues one cache operation at a time, tracks the cache busy handshake, and returns read data with a one-cycle ack to the granted client.

---
 rtl/cache_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-client arbiter (display fetcher, host port) in front of the byte cache.
// Define ARB_ROUND_ROBIN_EN to alternate grants instead of display priority with a starvation limit.
module cache_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ADDR_W       = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic [7:0]        d_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [7:0]        h_wdata,
  input  logic              h_bypass,
  input  logic              h_combine,
  output logic              h_ack,
  output logic [7:0]        h_rdata,
  output logic              c_enable,
  output logic              c_read,
  output logic              c_read_en,
  output logic              c_write_en,
  output logic              c_bypass,
  output logic              c_combine,
  output logic [ADDR_W-1:0] c_address,
  output logic [ADDR_W-1:0] c_raw_address,
  output logic [7:0]        c_data_in,
  input  logic              c_busy,
  input  logic [7:0]        c_data_out,
  output logic              owner,
  output logic [1:0]        arb_state
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [7:0] starve_ctr, starve_nx;
  logic       grant, grant_host, done;
  logic       host_combine;

  assign host_combine = h_bypass & h_combine & h_we;
  assign arb_state    = state;

  always_comb begin
    state_nx   = state;
    starve_nx  = starve_ctr;
    grant      = 1'b0;
    grant_host = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // An ack is still showing during the first IDLE cycle; holding off here forms the gap cycle.
        if (!d_ack && !h_ack && (d_req || h_req)) begin
          grant    = 1'b1;
          state_nx = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          grant_host = h_req && (!d_req || !owner);
`else
          grant_host = h_req && (!d_req || starve_ctr == LIMIT);
`endif
        end
`ifdef ARB_ROUND_ROBIN_EN
        starve_nx = '0;
`else
        if (!h_req || grant_host) starve_nx = '0;
        else if (grant && starve_ctr != LIMIT) starve_nx = starve_ctr + 8'd1;
`endif
      end
      ISSUE:  state_nx = SETTLE;
      SETTLE: begin
        state_nx = c_busy ? WAIT : IDLE;
        done     = !c_busy;
      end
      WAIT: begin
        if (!c_busy) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      starve_ctr    <= '0;
      c_enable      <= 1'b0;
      c_read        <= 1'b0;
      c_read_en     <= 1'b0;
      c_write_en    <= 1'b0;
      c_bypass      <= 1'b0;
      c_combine     <= 1'b0;
      c_address     <= '0;
      c_raw_address <= '0;
      c_data_in     <= '0;
      d_ack         <= 1'b0;
      h_ack         <= 1'b0;
      d_rdata       <= '0;
      h_rdata       <= '0;
      owner         <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_ctr <= starve_nx;
      c_enable   <= grant;
      d_ack      <= done && !owner;
      h_ack      <= done && owner;
      if (grant) begin
        owner <= grant_host;
        if (grant_host) begin
          c_read        <= !h_we;
          c_read_en     <= !h_we;
          c_write_en    <= h_we;
          c_bypass      <= h_bypass;
          c_combine     <= host_combine;
          c_address     <= host_combine ? {1'b0, h_addr[ADDR_W-1:1]} : h_addr;
          c_raw_address <= h_addr;
          c_data_in     <= h_wdata;
        end else begin
          c_read        <= 1'b1;
          c_read_en     <= 1'b1;
          c_write_en    <= 1'b0;
          c_bypass      <= 1'b0;
          c_combine     <= 1'b0;
          c_address     <= d_addr;
          c_raw_address <= d_addr;
        end
      end
      if (state == WAIT && !c_busy && c_read) begin
        if (owner) h_rdata <= c_data_out;
        else       d_rdata <= c_data_out;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: random clients, a cache responder, and a rule-level grant model.
module tb_cache_arbiter;
  localparam int unsigned AW  = 24;
  localparam int unsigned LIM = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          d_req = 1'b0, h_req = 1'b0, h_we = 1'b0, h_bypass = 1'b0, h_combine = 1'b0;
  logic [AW-1:0] d_addr = '0, h_addr = '0;
  logic [7:0]    h_wdata = '0;
  logic          c_busy = 1'b0;
  logic [7:0]    c_data_out = '0;
  logic          d_ack, h_ack, c_enable, c_read, c_read_en, c_write_en, c_bypass, c_combine, owner;
  logic [7:0]    d_rdata, h_rdata, c_data_in;
  logic [AW-1:0] c_address, c_raw_address;
  logic [1:0]    arb_state;

  cache_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_bypass(h_bypass), .h_combine(h_combine), .h_ack(h_ack), .h_rdata(h_rdata),
    .c_enable(c_enable), .c_read(c_read), .c_read_en(c_read_en), .c_write_en(c_write_en),
    .c_bypass(c_bypass), .c_combine(c_combine), .c_address(c_address),
    .c_raw_address(c_raw_address), .c_data_in(c_data_in), .c_busy(c_busy),
    .c_data_out(c_data_out), .owner(owner), .arb_state(arb_state)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0, errors = 0, cyc = 0;
  bit          rst_seen = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    rst_seen = reset;
  end

  // Expected completion of one granted operation.
  typedef struct {
    bit          host;
    bit          rd;
    bit          busy;
    bit [7:0]    data;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  int          force_n = -1;
  bit          force_data_en = 1'b0;
  logic [7:0]  force_data = '0;
  bit          pend_valid = 1'b0;
  int unsigned pend_n = 0;
  logic [7:0]  pend_data = '0;

  // Cache responder: busy goes high the cycle after the strobe and stays for pend_n cycles.
  initial begin
    bit          r;
    int unsigned cnt;
    logic [7:0]  dat;
    cnt = 0;
    dat = '0;
    forever begin
      @(posedge clock);
      r = reset;
      #1;
      if (r) begin
        c_busy = 1'b0;
        cnt    = 0;
      end else if (pend_valid) begin
        pend_valid = 1'b0;
        cnt        = pend_n;
        dat        = pend_data;
        c_busy     = (cnt > 0);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          c_busy     = 1'b0;
          c_data_out = dat;
        end
      end
    end
  end

  // Monitor with reference model: grant rules, expected c_* fields, ack timing and read data.
  initial begin
    logic          s_dreq, s_hreq, s_hwe, s_hbyp, s_hcomb;
    logic [AW-1:0] s_daddr, s_haddr;
    logic [7:0]    s_hwdata, exp_drd, exp_hrd;
    int unsigned   streak, n;
    bit            last_owner, w, prev_en, hc;
    exp_t          e;
    s_dreq = 0; s_hreq = 0; s_hwe = 0; s_hbyp = 0; s_hcomb = 0;
    s_daddr = '0; s_haddr = '0; s_hwdata = '0; exp_drd = '0; exp_hrd = '0;
    streak = 0; last_owner = 0; prev_en = 0;
    forever begin
      @(negedge clock);
      if (rst_seen) begin
        sb.delete();
        streak = 0; last_owner = 0; exp_drd = '0; exp_hrd = '0; pend_valid = 1'b0;
        chk("reset arb_state", arb_state, 0);
        chk("reset c_enable", c_enable, 0);
        chk("reset acks", {d_ack, h_ack}, 0);
        chk("reset owner", owner, 0);
        chk("reset rdata", {d_rdata, h_rdata}, 0);
        chk("reset c flags", {c_read, c_read_en, c_write_en, c_bypass, c_combine}, 0);
        chk("reset c_address", c_address, 0);
        chk("reset c_raw_address", c_raw_address, 0);
        chk("reset c_data_in", c_data_in, 0);
      end else begin
        if (d_ack || h_ack) begin
          chk("acks exclusive", d_ack & h_ack, 0);
          if (sb.size() == 0) chk("ack with empty scoreboard", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("ack client", h_ack, e.host);
            chk("ack cycle", cyc, e.cyc);
            if (e.rd && e.busy) begin
              if (e.host) exp_hrd = e.data;
              else        exp_drd = e.data;
            end
            if (e.host) chk("h_rdata", h_rdata, exp_hrd);
            else        chk("d_rdata", d_rdata, exp_drd);
          end
        end
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          chk("ack by expected cycle", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
        if (c_enable) begin
          chk("c_enable single pulse", prev_en, 0);
          chk("grant has request", s_dreq | s_hreq, 1);
`ifdef ARB_ROUND_ROBIN_EN
          if (s_dreq && s_hreq) w = !last_owner;
          else                  w = s_hreq;
`else
          // streak = display grants made while the host has been waiting
          w = s_hreq && (!s_dreq || streak == LIM);
          if (!s_hreq || w)    streak = 0;
          else if (streak < LIM) streak++;
`endif
          last_owner = w;
          chk("owner", owner, w);
          if (w) begin
            hc = s_hbyp && s_hcomb && s_hwe;
            chk("host c_read", c_read, !s_hwe);
            chk("host c_read_en", c_read_en, !s_hwe);
            chk("host c_write_en", c_write_en, s_hwe);
            chk("host c_bypass", c_bypass, s_hbyp);
            chk("host c_combine", c_combine, hc);
            chk("host c_address", c_address, hc ? (s_haddr >> 1) : s_haddr);
            chk("host c_raw_address", c_raw_address, s_haddr);
            chk("host c_data_in", c_data_in, s_hwdata);
          end else begin
            chk("disp c flags", {c_read, c_read_en, c_write_en, c_bypass, c_combine}, 5'b11000);
            chk("disp c_address", c_address, s_daddr);
            chk("disp c_raw_address", c_raw_address, s_daddr);
          end
          n = (force_n >= 0) ? int'(force_n) : $urandom_range(0, 3);
          pend_n     = n;
          pend_data  = force_data_en ? force_data : 8'($urandom);
          pend_valid = 1'b1;
          e.host = w;
          e.rd   = w ? !s_hwe : 1'b1;
          e.busy = (n > 0);
          e.data = pend_data;
          e.cyc  = cyc + 2 + n;
          sb.push_back(e);
        end
      end
      prev_en  = c_enable;
      s_dreq   = d_req;   s_daddr = d_addr;
      s_hreq   = h_req;   s_hwe   = h_we;     s_haddr = h_addr;
      s_hwdata = h_wdata; s_hbyp  = h_bypass; s_hcomb = h_combine;
    end
  end

  task automatic do_display(input logic [AW-1:0] a, input int unsigned gap, output int unsigned lat);
    int unsigned t0;
    bit          got;
    @(posedge clock); #1;
    d_req = 1'b1; d_addr = a; t0 = cyc; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (d_ack) begin got = 1'b1; break; end
    end
    chk("d_ack within bound", got, 1);
    lat = cyc - t0;
    if (gap > 0) begin
      @(posedge clock); #1;
      d_req = 1'b0;
      repeat (gap - 1) @(posedge clock);
    end
  endtask

  task automatic do_host(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                         input logic byp, input logic comb, input int unsigned gap,
                         output int unsigned lat);
    int unsigned t0;
    bit          got;
    @(posedge clock); #1;
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd; h_bypass = byp; h_combine = comb;
    t0 = cyc; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (h_ack) begin got = 1'b1; break; end
    end
    chk("h_ack within bound", got, 1);
    lat = cyc - t0;
    if (gap > 0) begin
      @(posedge clock); #1;
      h_req = 1'b0;
      repeat (gap - 1) @(posedge clock);
    end
  endtask

  int unsigned lat_m, lat_d, lat_h;

  initial begin
    bit got;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    force_n = 2; force_data_en = 1'b1; force_data = 8'h5A;
    do_display(24'h001234, 1, lat_m);
    chk("display read data", d_rdata, 8'h5A);

    force_n = 3; force_data = 8'hEE;
    do_host(1'b1, 24'h000101, 8'hC3, 1'b1, 1'b1, 1, lat_m);
    chk("combine c_address", c_address, 24'h000080);
    chk("combine c_raw_address", c_raw_address, 24'h000101);
    chk("combine c_combine", c_combine, 1);
    chk("combine c_write_en", c_write_en, 1);
    chk("write leaves h_rdata", h_rdata, 0);

    force_n = 0;
    do_host(1'b1, 24'h000100, 8'h3C, 1'b1, 1'b1, 1, lat_m);
    chk("no-busy latency", lat_m, 3);

    force_n = -1; force_data_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 36; i++) do_display(AW'($urandom), (i == 35) ? 1 : 0, lat_d);
      end
      begin
        for (int i = 0; i < 4; i++)
          do_host(1'($urandom), AW'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  (i == 3) ? 1 : 0, lat_h);
      end
    join

    force_n = 3;
    @(posedge clock); #1;
    d_req = 1'b1; d_addr = 24'h00ABCD; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (arb_state == 2'd3) begin got = 1'b1; break; end
    end
    chk("reached WAIT", got, 1);
    @(posedge clock); #1;
    reset = 1'b1; d_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    force_n = 1;
    do_display(24'h000042, 1, lat_m);
    chk("post-reset latency", lat_m, 4);

    force_n = -1;
    fork
      begin
        for (int i = 0; i < 60; i++)
          do_display(AW'($urandom), (i == 59) ? 1 : $urandom_range(0, 3), lat_d);
      end
      begin
        for (int i = 0; i < 60; i++)
          do_host(1'($urandom), AW'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  (i == 59) ? 1 : $urandom_range(0, 3), lat_h);
      end
    join

    repeat (12) @(posedge clock);
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
